fifo_word_packer: RTL
=====================

Name: fifo_word_packer

Overview:
- Downstream consumer of the byte FIFO: pops IN_WIDTH-bit entries through the FIFO read port (ren/rdata/empty) and packs PACK_RATIO consecutive entries into one OUT_WIDTH-bit word.
- Presents each packed word on a valid/ready output to the next stage (bus/DMA writer).
- Hides the FIFO's one-cycle read latency.
- Sustains one FIFO pop per cycle while the output side accepts.

Parameters:
- IN_WIDTH, 8, FIFO entry width; must equal the FIFO's DATA_WIDTH.
- PACK_RATIO, 4, entries per output word; must be >= 2.
- OUT_WIDTH, IN_WIDTH*PACK_RATIO, packed word width (derived, not overridden).
- LANE_W, $clog2(PACK_RATIO+1), width of the lane counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fifo_ren  out  1  read enable to the FIFO.
- fifo_rdata  in  IN_WIDTH  FIFO read data, valid the cycle after fifo_ren is accepted.
- fifo_empty  in  1  FIFO empty flag.
- out_valid  out  1  packed word available.
- out_ready  in  1  downstream accepts the word.
- out_data  out  OUT_WIDTH  packed word.
- flush  in  1  emit the partial word (only with PACKER_FLUSH_EN).
- out_keep  out  PACK_RATIO  lane-valid mask (only with PACKER_FLUSH_EN).

Behaviour:
- Reset: fifo_ren=0, out_valid=0, out_data=0, out_keep=0, lane_cnt=0, rd_pend=0, asm register=0.
  - Reset is asynchronous and may assert mid-word. Partial and in-flight data are discarded. The FIFO is reset by the same rst_n.
- Read issue:
  - fifo_ren = !fifo_empty && (lane_cnt_next + rd_pend_next < PACK_RATIO).
  - fifo_ren is never asserted while fifo_empty=1.
  - rd_pend is 1 in the cycle after a read is issued.
- Landing:
  - When rd_pend=1, fifo_rdata is written into asm lane lane_cnt. Lane 0 occupies bits [IN_WIDTH-1:0] (little-endian); the next lane sits above it.
  - lane_cnt then increments.
- Word completion: when lane_cnt reaches PACK_RATIO, one of two cases applies.
  - Output register empty, or out_valid && out_ready this cycle: asm is copied to out_data, out_valid=1 next cycle, and lane_cnt returns to 0 in the same edge.
  - Otherwise: asm holds full (state ASM_FULL). Reads stall by the issue rule until the output register drains.
- Latency: out_valid rises 1 cycle after the last entry lands, which is 2 cycles after its fifo_ren.
- Output handshake:
  - out_data is stable while out_valid && !out_ready.
  - out_valid drops only after a transfer (valid && ready).
  - out_ready may toggle arbitrarily and has no combinational path to out_valid.
- Throughput: with FIFO non-empty and out_ready=1, fifo_ren is high every cycle and one word is produced every PACK_RATIO cycles.
- States: FILL (lane_cnt<PACK_RATIO), ASM_FULL (lane_cnt==PACK_RATIO, output busy). The output register has independent states EMPTY/HELD.
- Boundaries:
  - FIFO goes empty mid-word: the partial word is held indefinitely and nothing is emitted.
  - Empty and in-flight landing in the same cycle: the landing is still captured.
  - Simultaneous output transfer and asm completion: the new word moves directly into the output register with no bubble.

Optional Feature:
- Macro: PACKER_FLUSH_EN.
- With the macro defined:
  - flush and out_keep ports exist.
  - A flush pulse is recorded as pending. Once rd_pend=0, any partial word is pushed to the output with out_keep bit i = (i < lane_cnt). Unfilled lanes are zero.
  - New reads are blocked while flush is pending.
  - Flush with lane_cnt=0 emits nothing.
  - Full words carry out_keep all ones.
- Without the macro: no flush or out_keep ports, and partial words wait for completion.

Decomposition:
- Package fifo_pkg:
  - Default DATA_WIDTH/IN_WIDTH constant.
  - PACK_RATIO default.
  - asm-state enum {FILL, ASM_FULL}.
  - out-register state enum {OUT_EMPTY, OUT_HELD}.
- One natural sub-module: packer_out_reg, the output holding register with valid/ready (and out_keep when enabled). Everything else stays in fifo_word_packer.

Test Plan:
- Push 0x11,0x22,0x33,0x44 into the FIFO with out_ready=1.
  - Expect one word 0x44332211 with out_valid high exactly 1 cycle after the last landing.
  - fifo_ren high 4 consecutive cycles.
- Stream 16 bytes 0x00..0x0F with out_ready=1.
  - Expect 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C on consecutive 4-cycle boundaries.
  - No fifo_ren gaps.
- Hold out_ready=0 while streaming 12 bytes.
  - First word is held, asm fills to ASM_FULL, and fifo_ren stops after 8 pops.
  - Releasing out_ready drains words in order with none lost or duplicated.
- Push 3 bytes then leave the FIFO empty.
  - No out_valid, and fifo_ren is never high while fifo_empty=1.
  - A 4th byte pushed later completes the word correctly.
- Assert rst_n low while lane_cnt=2 and out_valid=1.
  - All outputs go 0 immediately (asynchronously).
  - After release, the next 4 bytes form a clean word.
- (PACKER_FLUSH_EN) Push 0xAA,0xBB, then pulse flush.
  - Expect out_data=0x0000BBAA, out_keep=4'b0011.
  - A subsequent full word has out_keep=4'b1111.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and state encodings for the FIFO word packer.
package fifo_pkg;
  localparam int DATA_WIDTH     = 8;
  localparam int PACK_RATIO_DEF = 4;

  typedef enum logic {FILL, ASM_FULL} asm_state_e;
  typedef enum logic {OUT_EMPTY, OUT_HELD} out_state_e;
endpackage

// File: rtl/packer_out_reg.sv
// Output holding register with valid/ready handshake for the word packer.
// With PACKER_FLUSH_EN defined, a lane-valid mask travels with each word.
module packer_out_reg
  import fifo_pkg::*;
#(
  parameter int OUT_WIDTH = 32
`ifdef PACKER_FLUSH_EN
  , parameter int KEEP_W = 4
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [OUT_WIDTH-1:0] load_data,
`ifdef PACKER_FLUSH_EN
  input  logic [KEEP_W-1:0]    load_keep,
  output logic [KEEP_W-1:0]    out_keep,
`endif
  input  logic                 out_ready,
  output logic                 can_load,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data
);
  out_state_e state_q, state_d;

  assign out_valid = (state_q == OUT_HELD);
  // A word may be loaded into the same edge that hands the current one over.
  assign can_load  = !out_valid || out_ready;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = OUT_HELD;
    end else if (out_valid && out_ready) begin
      state_d = OUT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= OUT_EMPTY;
      out_data <= '0;
`ifdef PACKER_FLUSH_EN
      out_keep <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (load) begin
        out_data <= load_data;
`ifdef PACKER_FLUSH_EN
        out_keep <= load_keep;
`endif
      end
    end
  end
endmodule

// File: rtl/fifo_word_packer.sv
// Pops IN_WIDTH entries from the byte FIFO and packs PACK_RATIO of them into one word.
// Optional PACKER_FLUSH_EN adds flush/out_keep for emitting partial words.
//
// state    | meaning
// FILL     | lane_cnt < PACK_RATIO, entries are landing into asm
// ASM_FULL | all lanes filled, waiting for the output register to drain
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int IN_WIDTH   = DATA_WIDTH,
  parameter int PACK_RATIO = PACK_RATIO_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  output logic                           fifo_ren,
  input  logic [IN_WIDTH-1:0]            fifo_rdata,
  input  logic                           fifo_empty,
  output logic                           out_valid,
  input  logic                           out_ready,
`ifdef PACKER_FLUSH_EN
  input  logic                           flush,
  output logic [PACK_RATIO-1:0]          out_keep,
`endif
  output logic [IN_WIDTH*PACK_RATIO-1:0] out_data
);
  localparam int OUT_WIDTH = IN_WIDTH * PACK_RATIO;
  localparam int LANE_W    = $clog2(PACK_RATIO + 1);

  asm_state_e             state_q, state_d;
  logic [LANE_W-1:0]      lane_q, lane_d;
  logic                   rd_pend_q;
  logic [OUT_WIDTH-1:0]   asm_q, asm_d, asm_landed, load_data;
  logic                   load, can_load, read_block;
`ifdef PACKER_FLUSH_EN
  logic                   flush_pend_q, flush_pend_d;
  logic [PACK_RATIO-1:0]  load_keep;

  function automatic logic [PACK_RATIO-1:0] lane_mask(input logic [LANE_W-1:0] n);
    logic [PACK_RATIO-1:0] m;
    for (int i = 0; i < PACK_RATIO; i++) m[i] = (LANE_W'(i) < n);
    return m;
  endfunction
`endif

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    asm_d      = asm_q;
    load       = 1'b0;
    load_data  = asm_q;
    asm_landed = asm_q;
    read_block = 1'b0;
`ifdef PACKER_FLUSH_EN
    flush_pend_d = flush_pend_q | flush;
    load_keep    = '1;
    read_block   = flush | flush_pend_q;
`endif
    for (int i = 0; i < PACK_RATIO; i++) begin
      if (lane_q == LANE_W'(i)) asm_landed[i*IN_WIDTH +: IN_WIDTH] = fifo_rdata;
    end

    case (state_q)
      FILL: begin
        if (rd_pend_q) begin
          if (lane_q == LANE_W'(PACK_RATIO - 1)) begin
            // Completing entry bypasses asm so out_valid follows the landing by one cycle.
            if (can_load) begin
              load      = 1'b1;
              load_data = asm_landed;
              asm_d     = '0;
              lane_d    = '0;
            end else begin
              asm_d   = asm_landed;
              lane_d  = LANE_W'(PACK_RATIO);
              state_d = ASM_FULL;
            end
          end else begin
            asm_d  = asm_landed;
            lane_d = lane_q + LANE_W'(1);
          end
        end
`ifdef PACKER_FLUSH_EN
        else if (flush_pend_q) begin
          if (lane_q == '0) begin
            flush_pend_d = flush;
          end else if (can_load) begin
            load         = 1'b1;
            load_keep    = lane_mask(lane_q);
            asm_d        = '0;
            lane_d       = '0;
            flush_pend_d = flush;
          end
        end
`endif
      end
      ASM_FULL: begin
        if (can_load) begin
          load    = 1'b1;
          asm_d   = '0;
          lane_d  = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    fifo_ren = !fifo_empty && (lane_d < LANE_W'(PACK_RATIO)) && !read_block;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      lane_q    <= '0;
      rd_pend_q <= 1'b0;
      asm_q     <= '0;
`ifdef PACKER_FLUSH_EN
      flush_pend_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      rd_pend_q <= fifo_ren;
      asm_q     <= asm_d;
`ifdef PACKER_FLUSH_EN
      flush_pend_q <= flush_pend_d;
`endif
    end
  end

  packer_out_reg #(
    .OUT_WIDTH (OUT_WIDTH)
`ifdef PACKER_FLUSH_EN
    , .KEEP_W  (PACK_RATIO)
`endif
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (load_data),
`ifdef PACKER_FLUSH_EN
    .load_keep (load_keep),
    .out_keep  (out_keep),
`endif
    .out_ready (out_ready),
    .can_load  (can_load),
    .out_valid (out_valid),
    .out_data  (out_data)
  );
endmodule
